// File: rtl/rename_alloc_ctrl.sv
// rename_alloc_ctrl: physical-register free list with speculative/commit heads and flush recovery
module rename_alloc_ctrl #(
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 64,
    parameter int RENAME_WIDTH = 2,
    parameter int AW           = $clog2(NUM_AREGS),
    parameter int PW           = $clog2(NUM_PREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [RENAME_WIDTH-1:0]    alloc_mask,
    input  logic [RENAME_WIDTH*AW-1:0] alloc_dst_areg,
    output logic                       alloc_ready,
    output logic [RENAME_WIDTH*PW-1:0] alloc_preg,
    output logic                       rat_w_en,
    output logic [RENAME_WIDTH-1:0]    rat_w_mask,
    output logic [RENAME_WIDTH*AW-1:0] rat_dst_areg,
    output logic [RENAME_WIDTH*PW-1:0] rat_new_alias,
    input  logic [RENAME_WIDTH-1:0]    free_mask,
    input  logic [RENAME_WIDTH*PW-1:0] free_preg,
    input  logic [RENAME_WIDTH-1:0]    commit_mask,
    input  logic                       flush,
    output logic [PW:0]                free_count
);
    typedef enum logic [1:0] {INIT, RUN, RECOVER} state_t;
    localparam logic [PW+1:0] NP2       = NUM_PREGS[PW+1:0];
    localparam logic [PW:0]   NP1       = NUM_PREGS[PW:0];
    localparam logic [PW-1:0] AREG_BASE = PW'(NUM_AREGS);
    localparam logic [PW-1:0] INIT_LAST = PW'(NUM_PREGS - NUM_AREGS - 1);
    localparam logic [PW-1:0] INIT_TAIL = PW'(NUM_PREGS - NUM_AREGS);
    localparam logic [PW:0]   INIT_FC   = (PW+1)'(NUM_PREGS - NUM_AREGS);

    state_t state, state_n;
    logic [PW-1:0] fl [NUM_PREGS];
    logic [PW-1:0] spec_head, commit_head, tail, init_k, commit_n, tail_n;
    logic [PW:0] fc, alloc_cnt, free_cnt, commit_cnt, used, diff, flush_fc;
    logic [PW+1:0] fc_sum;
    logic fire, do_flush;

    // count of set bits in m below lane n; n = RENAME_WIDTH gives the total
    function automatic logic [PW:0] pop(input logic [RENAME_WIDTH-1:0] m, input int n);
        logic [PW:0] c = '0;
        for (int i = 0; i < RENAME_WIDTH; i++)
            if (i < n && m[i]) c = c + 1'b1;
        return c;
    endfunction

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [PW:0] n);
        logic [PW+1:0] s = {2'b0, p} + {1'b0, n};
        return (s >= NP2) ? PW'(s - NP2) : PW'(s);
    endfunction

    always_comb begin
        alloc_cnt   = pop(alloc_mask, RENAME_WIDTH);
        free_cnt    = pop(free_mask, RENAME_WIDTH);
        commit_cnt  = pop(commit_mask, RENAME_WIDTH);
        alloc_ready = !rst && state == RUN && !flush && fc >= alloc_cnt;
        fire        = alloc_valid && alloc_ready;
        do_flush    = state == RUN && flush;
        used        = fire ? alloc_cnt : '0;
        commit_n    = wrap(commit_head, commit_cnt);
        tail_n      = wrap(tail, free_cnt);
        fc_sum      = {1'b0, fc} + {1'b0, free_cnt} - {1'b0, used};
        diff        = (tail_n >= commit_n) ? {1'b0, tail_n} - {1'b0, commit_n}
                                           : {1'b0, tail_n} + NP1 - {1'b0, commit_n};
        // equal pointers are ambiguous: treat as full unless the list was already empty
        flush_fc    = (diff == '0 && fc != '0) ? NP1 : diff;
        state_n     = state == INIT ? (init_k == INIT_LAST ? RUN : INIT)
                    : state == RUN  ? (flush ? RECOVER : RUN) : RUN;
        rat_w_en    = fire && |alloc_mask;
        rat_w_mask  = fire ? alloc_mask : '0;
        free_count  = rst ? '0 : fc;
    end

    for (genvar i = 0; i < RENAME_WIDTH; i++) begin : g_lane
        assign alloc_preg[i*PW +: PW] = fl[wrap(spec_head, pop(alloc_mask, i))];
    end

    assign rat_dst_areg  = alloc_dst_areg;
    assign rat_new_alias = alloc_preg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_k      <= '0;
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= '0;
            fc          <= '0;
        end else begin
            state <= state_n;
            if (state == INIT) begin
                init_k <= init_k + 1'b1;
                if (init_k == INIT_LAST) begin
                    tail <= INIT_TAIL;
                    fc   <= INIT_FC;
                end
            end else begin
                tail        <= tail_n;
                commit_head <= commit_n;
                spec_head   <= do_flush ? commit_n : wrap(spec_head, used);
                fc          <= do_flush ? flush_fc : fc_sum[PW:0];
            end
        end
    end

    // free-list storage carries no reset; INIT fills it after every reset
    always_ff @(posedge clk) begin
        if (!rst && state == INIT)
            fl[init_k] <= AREG_BASE + init_k;
        else if (!rst)
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (free_mask[i]) fl[wrap(tail, pop(free_mask, i))] <= free_preg[i*PW +: PW];
    end

    assert property (@(posedge clk) disable iff (rst) state != INIT |-> fc_sum <= {1'b0, NP1})
        else $error("free list overflow: free_count would exceed NUM_PREGS");
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb_rename_alloc_ctrl: directed self-checking bench for rename_alloc_ctrl
module tb_rename_alloc_ctrl;
    localparam int AW = 5, PW = 6, RW = 2;
    logic clk = 0, rst = 1;
    logic alloc_valid, alloc_ready, rat_w_en, flush;
    logic [RW-1:0] alloc_mask, rat_w_mask, free_mask, commit_mask;
    logic [RW*AW-1:0] alloc_dst_areg, rat_dst_areg;
    logic [RW*PW-1:0] alloc_preg, rat_new_alias, free_preg;
    logic [PW:0] free_count;
    int tests = 0, fails = 0;

    rename_alloc_ctrl dut (
        .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_mask(alloc_mask),
        .alloc_dst_areg(alloc_dst_areg), .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
        .rat_w_en(rat_w_en), .rat_w_mask(rat_w_mask), .rat_dst_areg(rat_dst_areg),
        .rat_new_alias(rat_new_alias), .free_mask(free_mask), .free_preg(free_preg),
        .commit_mask(commit_mask), .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alloc_valid = 0; alloc_mask = 0; alloc_dst_areg = 0;
        free_mask = 0; free_preg = 0; commit_mask = 0; flush = 0;
    endtask

    task automatic bring_up;
        idle;
        rst = 1;
        step; step;
        rst = 0;
        repeat (32) step;
    endtask

    task automatic test_reset;
        int rise = -1;
        idle;
        alloc_valid = 1; alloc_mask = 2'b11;
        rst = 1;
        step; step; #1;
        tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", alloc_ready); end
        tests++; if (rat_w_en !== 1'b0 || rat_w_mask !== 2'b00) begin fails++; $display("FAIL reset_rat: got en=%b mask=%b want 0/00", rat_w_en, rat_w_mask); end
        tests++; if (free_count !== 7'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", free_count); end
        rst = 0;
        idle;
        for (int n = 1; n <= 40; n++) begin
            step;
            if (n == 1) begin
                tests++; if (alloc_ready !== 1'b0 || free_count !== 7'd0) begin fails++; $display("FAIL post_reset: got ready=%b count=%0d want 0/0", alloc_ready, free_count); end
            end
            if (alloc_ready === 1'b1 && rise < 0) rise = n;
        end
        tests++; if (rise != 32) begin fails++; $display("FAIL init_latency: got %0d want 32", rise); end
        tests++; if (free_count !== 7'd32) begin fails++; $display("FAIL init_count: got %0d want 32", free_count); end
    endtask

    task automatic test_alloc_pair;
        bring_up;
        alloc_valid = 1; alloc_mask = 2'b11; alloc_dst_areg = {5'd5, 5'd3};
        #1;
        tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL pair_ready: got %b want 1", alloc_ready); end
        tests++; if (alloc_preg !== {6'd33, 6'd32}) begin fails++; $display("FAIL pair_preg: got %h want %h", alloc_preg, {6'd33, 6'd32}); end
        tests++; if (rat_w_en !== 1'b1 || rat_w_mask !== 2'b11) begin fails++; $display("FAIL pair_rat_en: got en=%b mask=%b want 1/11", rat_w_en, rat_w_mask); end
        tests++; if (rat_dst_areg !== {5'd5, 5'd3} || rat_new_alias !== {6'd33, 6'd32}) begin fails++; $display("FAIL pair_rat_data: got areg=%h alias=%h", rat_dst_areg, rat_new_alias); end
        step;
        alloc_mask = 2'b01; alloc_dst_areg = {5'd0, 5'd4};
        #1;
        tests++; if (alloc_preg[PW-1:0] !== 6'd34) begin fails++; $display("FAIL pair_next: got %0d want 34", alloc_preg[PW-1:0]); end
        tests++; if (free_count !== 7'd30) begin fails++; $display("FAIL pair_count: got %0d want 30", free_count); end
        step; idle;
    endtask

    task automatic test_single_lane;
        bring_up;
        alloc_valid = 1; alloc_mask = 2'b10; alloc_dst_areg = {5'd7, 5'd0};
        #1;
        tests++; if (alloc_preg[2*PW-1:PW] !== 6'd32) begin fails++; $display("FAIL lane1_preg: got %0d want 32", alloc_preg[2*PW-1:PW]); end
        tests++; if (rat_w_en !== 1'b1 || rat_w_mask !== 2'b10) begin fails++; $display("FAIL lane1_rat: got en=%b mask=%b want 1/10", rat_w_en, rat_w_mask); end
        step;
        alloc_mask = 2'b01; alloc_dst_areg = {5'd0, 5'd9};
        #1;
        tests++; if (alloc_preg[PW-1:0] !== 6'd33) begin fails++; $display("FAIL lane1_head: got %0d want 33", alloc_preg[PW-1:0]); end
        step; idle; #1;
        tests++; if (free_count !== 7'd30) begin fails++; $display("FAIL lane1_count: got %0d want 30", free_count); end
    endtask

    task automatic test_zero_mask;
        bring_up;
        alloc_valid = 1; alloc_mask = 2'b00;
        #1;
        tests++; if (alloc_ready !== 1'b1 || rat_w_en !== 1'b0 || rat_w_mask !== 2'b00) begin fails++; $display("FAIL zero_fire: got ready=%b en=%b mask=%b want 1/0/00", alloc_ready, rat_w_en, rat_w_mask); end
        step;
        alloc_mask = 2'b01;
        #1;
        tests++; if (alloc_preg[PW-1:0] !== 6'd32 || free_count !== 7'd32) begin fails++; $display("FAIL zero_noadv: got preg=%0d count=%0d want 32/32", alloc_preg[PW-1:0], free_count); end
        step; idle;
    endtask

    task automatic test_full;
        bring_up;
        alloc_valid = 1; alloc_mask = 2'b11;
        repeat (15) step;
        alloc_mask = 2'b01;
        step;
        alloc_mask = 2'b11;
        #1;
        tests++; if (free_count !== 7'd1 || alloc_ready !== 1'b0) begin fails++; $display("FAIL full_block: got count=%0d ready=%b want 1/0", free_count, alloc_ready); end
        free_mask = 2'b01; free_preg = {6'd0, 6'd32};
        #1;
        tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_same_cycle: got %b want 0", alloc_ready); end
        step;
        free_mask = 0;
        #1;
        tests++; if (alloc_ready !== 1'b1 || free_count !== 7'd2) begin fails++; $display("FAIL full_accept: got ready=%b count=%0d want 1/2", alloc_ready, free_count); end
        tests++; if (alloc_preg !== {6'd32, 6'd63}) begin fails++; $display("FAIL full_preg: got %h want %h", alloc_preg, {6'd32, 6'd63}); end
        step;
        alloc_mask = 2'b01;
        #1;
        tests++; if (free_count !== 7'd0 || alloc_ready !== 1'b0) begin fails++; $display("FAIL empty_block: got count=%0d ready=%b want 0/0", free_count, alloc_ready); end
        alloc_mask = 2'b00;
        #1;
        tests++; if (alloc_ready !== 1'b1 || rat_w_en !== 1'b0) begin fails++; $display("FAIL empty_zero: got ready=%b en=%b want 1/0", alloc_ready, rat_w_en); end
        step; idle;
    endtask

    task automatic test_flush;
        bring_up;
        alloc_valid = 1; alloc_mask = 2'b11;
        repeat (3) step;
        idle; commit_mask = 2'b11;
        step;
        commit_mask = 0; flush = 1; alloc_valid = 1; alloc_mask = 2'b01;
        #1;
        tests++; if (alloc_ready !== 1'b0 || rat_w_en !== 1'b0) begin fails++; $display("FAIL flush_nofire: got ready=%b en=%b want 0/0", alloc_ready, rat_w_en); end
        step;
        flush = 0;
        #1;
        tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL recover_ready: got %b want 0", alloc_ready); end
        tests++; if (free_count !== 7'd30) begin fails++; $display("FAIL flush_count: got %0d want 30", free_count); end
        step;
        tests++; if (alloc_ready !== 1'b1 || alloc_preg[PW-1:0] !== 6'd34) begin fails++; $display("FAIL flush_realloc: got ready=%b preg=%0d want 1/34", alloc_ready, alloc_preg[PW-1:0]); end
        step; idle;
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0] q[$];
        logic [PW-1:0] e0, e1, p0, p1;
        int bad = 0;
        bring_up;
        for (int k = 32; k < 64; k++) q.push_back(PW'(k));
        p0 = 0; p1 = 0;
        for (int c = 0; c < 100; c++) begin
            alloc_valid = 1; alloc_mask = 2'b11;
            alloc_dst_areg = {AW'(c + 1), AW'(c)};
            free_mask = (c > 0) ? 2'b11 : 2'b00;
            commit_mask = free_mask;
            free_preg = {p1, p0};
            e0 = q.pop_front();
            e1 = q.pop_front();
            #1;
            tests++;
            if (alloc_ready !== 1'b1 || alloc_preg !== {e1, e0} || (c > 0 && free_count !== 7'd30) ||
                (c > 0 && (alloc_preg[PW-1:0] == p0 || alloc_preg[PW-1:0] == p1 ||
                           alloc_preg[2*PW-1:PW] == p0 || alloc_preg[2*PW-1:PW] == p1))) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL b2b_cycle%0d: got ready=%b preg=%h count=%0d want 1/%h/30", c, alloc_ready, alloc_preg, free_count, {e1, e0});
            end
            if (c > 0) begin q.push_back(p0); q.push_back(p1); end
            p0 = e0; p1 = e1;
            step;
        end
        idle;
        free_mask = 2'b11; free_preg = {p1, p0};
        #1;
        tests++; if (free_count !== 7'd30) begin fails++; $display("FAIL b2b_steady: got %0d want 30", free_count); end
        step; idle; #1;
        tests++; if (free_count !== 7'd32) begin fails++; $display("FAIL b2b_final: got %0d want 32", free_count); end
    endtask

    initial begin
        idle;
        test_reset;
        test_alloc_pair;
        test_single_lane;
        test_zero_mask;
        test_full;
        test_flush;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rename_alloc_ctrl.md
RENAME_ALLOC_CTRL -- requirements
Module: rename_alloc_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_AREGS, 32, architectural registers; NUM_PREGS, 64, physical registers; RENAME_WIDTH, 2, rename lanes per cycle; AW = $clog2(NUM_AREGS); PW = $clog2(NUM_PREGS).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 alloc_valid  input  1  decode presents a rename bundle.
REQ-005 alloc_mask  input  RENAME_WIDTH  lane i needs a new preg (valid destination).
REQ-006 alloc_dst_areg  input  RENAME_WIDTH*AW  per-lane destination areg; lane i occupies bits [i*AW +: AW].
REQ-007 alloc_ready  output  1  bundle accepted this cycle if alloc_valid is also high.
REQ-008 alloc_preg  output  RENAME_WIDTH*PW  per-lane allocated preg, same packing as REQ-006; valid only on fire.
REQ-009 rat_w_en  output  1  RAT write strobe.
REQ-010 rat_w_mask  output  RENAME_WIDTH  lanes written into the RAT.
REQ-011 rat_dst_areg / rat_new_alias  output  RENAME_WIDTH*AW / RENAME_WIDTH*PW  RAT write address and data per lane.
REQ-012 free_mask / free_preg  input  RENAME_WIDTH / RENAME_WIDTH*PW  commit returns stale pregs.
REQ-013 commit_mask  input  RENAME_WIDTH  committed instructions that consumed an allocation.
REQ-014 flush  input  1  squash all speculative allocations.
REQ-015 free_count  output  PW+1  current number of allocatable pregs.

Function
REQ-016 Free list SHALL be a circular buffer of NUM_PREGS entries with PW-bit pointers wrapping modulo NUM_PREGS: spec_head, commit_head, tail.
REQ-017 FSM SHALL have states INIT, RUN, RECOVER; reset enters INIT.
REQ-018 INIT SHALL write preg NUM_AREGS+k into entry k, one entry per cycle, for k = 0..NUM_PREGS-NUM_AREGS-1, then enter RUN; alloc_ready = 0 throughout INIT.
REQ-019 On INIT exit: spec_head = commit_head = 0, tail = NUM_PREGS-NUM_AREGS (wraps to 0 if equal to NUM_PREGS), free_count = NUM_PREGS-NUM_AREGS.
REQ-020 alloc_ready SHALL be 1 only when state = RUN, flush = 0, and free_count >= popcount(alloc_mask).
REQ-021 Fire = alloc_valid & alloc_ready; allocation SHALL be all-or-nothing per bundle, with no partial allocation.
REQ-022 On fire, masked lanes SHALL take consecutive entries from spec_head in ascending lane order, skipping unmasked lanes; spec_head advances by popcount(alloc_mask).
REQ-023 On fire, rat_w_en = 1, rat_w_mask = alloc_mask, rat_dst_areg = alloc_dst_areg, rat_new_alias = alloc_preg, all combinational in the fire cycle (zero latency); otherwise rat_w_en = 0 and rat_w_mask = 0.
REQ-024 Fire with alloc_mask = 0 SHALL be accepted with rat_w_en = 0 and no pointer change.
REQ-025 Each free_mask lane SHALL write free_preg at tail in ascending lane order; tail advances by popcount(free_mask); accepted in every state except INIT.
REQ-026 commit_head SHALL advance by popcount(commit_mask) each cycle in RUN and RECOVER.
REQ-027 free_count next = free_count + popcount(free_mask) - popcount(allocated lanes); a preg freed in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-028 flush in RUN SHALL, on the next edge, set spec_head = commit_head (including that cycle's commit advance), set free_count = tail_next - commit_head_next (mod NUM_PREGS, with equal pointers meaning NUM_PREGS only if the previous count was nonzero), and enter RECOVER; no fire occurs in the flush cycle.
REQ-029 RECOVER SHALL last exactly one cycle with alloc_ready = 0, then return to RUN.
REQ-030 Full/empty: free_count = 0 blocks any nonzero request; a free_mask that would push free_count above NUM_PREGS is illegal and SHALL be flagged by a simulation assertion.

Reset
REQ-031 rst SHALL act at any state, including mid-INIT or mid-bundle, and restart INIT from k = 0.
REQ-032 While rst is high and in the cycle after: alloc_ready = 0, rat_w_en = 0, rat_w_mask = 0, free_count = 0; alloc_preg and rat_* data are don't-care.

Verification
REQ-033 Reset, then idle 40 cycles -> alloc_ready rises exactly 32 cycles after rst falls; free_count = 32.
REQ-034 Bundle mask 2'b11, areg {5,3} -> lane0 preg 32, lane1 preg 33, rat_w_en = 1 same cycle, free_count = 30.
REQ-035 Mask 2'b10, areg lane1 = 7 -> lane1 preg 32, rat_w_mask = 2'b10, spec_head = 1.
REQ-036 Drain to free_count = 1, then request 2'b11 -> alloc_ready = 0; free one preg that cycle -> accepted the next cycle.
REQ-037 Allocate 6 pregs, commit 2, flush -> after RECOVER, next allocation returns the third allocated preg; free_count = 30.
REQ-038 Allocate and free 2 per cycle for 100 cycles -> pointers wrap, free_count stays constant, no preg is duplicated.
